wishbone_arbiter_rr: RTL and testbench

- Round-robin arbiter that shares one WISHBONE slave port (typically the slave side of the WISHBONE-to-AXI4-Lite bridge) between NUM WISHBONE masters.
- Grants one requester at a time and holds the grant until the downstream ack (or a requester abort or timeout).
- Multiplexes the granted master's request onto the downstream port and routes read data and ack back to that master only.

---
 rtl/wishbone_arbiter_rr.sv | 130 +++++++++++++
 tb/tb_wishbone_arbiter_rr.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wishbone_arbiter_rr.sv
// Round-robin arbiter sharing one WISHBONE slave port between NUM masters.
// A grant is held until the downstream ack, a requester abort, or an optional
// timeout. There is always one IDLE bubble between consecutive grants.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_IDLE | no grant held; pick next requester after the last grant
//   ST_BUSY | granted master's request is muxed onto the downstream port
module wishbone_arbiter_rr #(
  parameter int NUM          = 2,
  parameter int SEL_BITS     = (NUM > 2) ? $clog2(NUM) : 1,
  parameter int WB_ADR_WIDTH = 30,
  parameter int WB_DAT_SIZE  = 2,
  parameter int WB_DAT_WIDTH = (8 << WB_DAT_SIZE),
  parameter int WB_SEL_WIDTH = WB_DAT_WIDTH / 8,
  parameter int TIMEOUT      = 0
) (
  input  logic                        s_wb_clk_i,
  input  logic                        s_wb_rst_i,
  input  logic [NUM*WB_ADR_WIDTH-1:0] s_wb_adr_i,
  output logic [WB_DAT_WIDTH-1:0]     s_wb_dat_o,
  input  logic [NUM*WB_DAT_WIDTH-1:0] s_wb_dat_i,
  input  logic [NUM*WB_SEL_WIDTH-1:0] s_wb_sel_i,
  input  logic [NUM-1:0]              s_wb_we_i,
  input  logic [NUM-1:0]              s_wb_stb_i,
  output logic [NUM-1:0]              s_wb_ack_o,
  output logic [WB_ADR_WIDTH-1:0]     m_wb_adr_o,
  input  logic [WB_DAT_WIDTH-1:0]     m_wb_dat_i,
  output logic [WB_DAT_WIDTH-1:0]     m_wb_dat_o,
  output logic [WB_SEL_WIDTH-1:0]     m_wb_sel_o,
  output logic                        m_wb_we_o,
  output logic                        m_wb_stb_o,
  input  logic                        m_wb_ack_i,
  output logic                        busy,
  output logic [SEL_BITS-1:0]         grant,
  output logic                        timeout
);

  typedef enum logic {ST_IDLE, ST_BUSY} state_t;

  localparam bit          TO_EN   = (TIMEOUT != 0);
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);

  state_t              state_q, state_d;
  logic [SEL_BITS-1:0] grant_q, grant_d;
  logic [31:0]         timer_q, timer_d;

  logic                found;
  logic [SEL_BITS-1:0] pick;
  logic [SEL_BITS-1:0] cand;
  logic                stb_gnt;
  logic                ack_hit;
  logic                to_hit;

  // Round-robin search starting just after the last granted index.
  always_comb begin
    found = 1'b0;
    pick  = grant_q;
    cand  = '0;
    for (int i = 1; i <= NUM; i++) begin
      cand = SEL_BITS'((int'(grant_q) + i) % NUM);
      if (!found && s_wb_stb_i[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // Downstream request fields always follow the grant index; the slave
  // only looks at them while m_wb_stb_o is high.
  always_comb begin
    m_wb_adr_o = s_wb_adr_i[int'(grant_q)*WB_ADR_WIDTH +: WB_ADR_WIDTH];
    m_wb_dat_o = s_wb_dat_i[int'(grant_q)*WB_DAT_WIDTH +: WB_DAT_WIDTH];
    m_wb_sel_o = s_wb_sel_i[int'(grant_q)*WB_SEL_WIDTH +: WB_SEL_WIDTH];
    m_wb_we_o  = s_wb_we_i[grant_q];
    s_wb_dat_o = m_wb_dat_i;
  end

  // Next-state, timer and handshake outputs.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    timer_d    = timer_q;
    stb_gnt    = s_wb_stb_i[grant_q];
    ack_hit    = 1'b0;
    to_hit     = 1'b0;
    m_wb_stb_o = 1'b0;
    s_wb_ack_o = '0;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          state_d = ST_BUSY;
          grant_d = pick;
          timer_d = '0;
        end
      end
      ST_BUSY: begin
        ack_hit = stb_gnt & m_wb_ack_i;
        // A real ack on the last allowed cycle wins over the timeout.
        to_hit  = TO_EN && !ack_hit && (timer_q == TO_LAST);
        m_wb_stb_o = stb_gnt & ~to_hit;
        s_wb_ack_o[grant_q] = ack_hit;
        if (ack_hit || !stb_gnt || to_hit) begin
          state_d = ST_IDLE;
        end else if (timer_q != '1) begin
          timer_d = timer_q + 32'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy    = (state_q == ST_BUSY);
  assign grant   = grant_q;
  assign timeout = to_hit;

  // State register; reset parks the grant on NUM-1 so master 0 wins first.
  always_ff @(posedge s_wb_clk_i) begin
    if (s_wb_rst_i) begin
      state_q <= ST_IDLE;
      grant_q <= SEL_BITS'(NUM - 1);
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      timer_q <= timer_d;
    end
  end

endmodule

// File: tb/tb_wishbone_arbiter_rr.sv
// Scoreboard bench for wishbone_arbiter_rr (NUM=4, TIMEOUT=8).
module tb_wishbone_arbiter_rr;

  localparam int EV_GRANT = 1;
  localparam int EV_ACK   = 2;
  localparam int EV_TO    = 3;

  typedef struct {
    int          kind;
    logic [1:0]  g;
    logic [3:0]  ack;
    logic [29:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
    logic [31:0] rdat;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [119:0]  s_adr;
  logic [31:0]   s_dat_o;
  logic [127:0]  s_dat_i;
  logic [15:0]   s_sel;
  logic [3:0]    s_we, s_stb, s_ack;
  logic [29:0]   m_adr;
  logic [31:0]   m_dat_i, m_dat_o;
  logic [3:0]    m_sel;
  logic          m_we, m_stb, m_ack, busy, timeout;
  logic [1:0]    grant;

  ev_t           exp_q[$];
  int            n_checks = 0;
  int            n_pass   = 0;
  logic [3:0]    ack_seen = '0;
  logic [3:0]    drop_mask = 4'hF;
  logic          busy_prev = 1'b0;
  logic          slave_en = 1'b1;
  int            slave_lat = -1;
  int            slave_cnt = 0;

  logic [29:0]   cfg_adr[4];
  logic [31:0]   cfg_dat[4];
  logic [3:0]    cfg_sel[4];
  logic          cfg_we[4];

  wishbone_arbiter_rr #(.NUM(4), .TIMEOUT(8)) dut (
    .s_wb_clk_i(clk), .s_wb_rst_i(rst),
    .s_wb_adr_i(s_adr), .s_wb_dat_o(s_dat_o), .s_wb_dat_i(s_dat_i),
    .s_wb_sel_i(s_sel), .s_wb_we_i(s_we), .s_wb_stb_i(s_stb), .s_wb_ack_o(s_ack),
    .m_wb_adr_o(m_adr), .m_wb_dat_i(m_dat_i), .m_wb_dat_o(m_dat_o),
    .m_wb_sel_o(m_sel), .m_wb_we_o(m_we), .m_wb_stb_o(m_stb), .m_wb_ack_i(m_ack),
    .busy(busy), .grant(grant), .timeout(timeout)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic set_master(input int k, input logic [29:0] adr, input logic [31:0] dat,
                            input logic [3:0] sel, input logic we);
    cfg_adr[k] = adr; cfg_dat[k] = dat; cfg_sel[k] = sel; cfg_we[k] = we;
    s_adr[k*30 +: 30] = adr;
    s_dat_i[k*32 +: 32] = dat;
    s_sel[k*4 +: 4] = sel;
    s_we[k] = we;
  endtask

  task automatic exp_grant(input int k);
    ev_t e;
    e.kind = EV_GRANT; e.g = 2'(k); e.ack = '0; e.adr = cfg_adr[k]; e.dat = cfg_dat[k];
    e.sel = cfg_sel[k]; e.we = cfg_we[k]; e.rdat = '0;
    exp_q.push_back(e);
  endtask

  task automatic exp_ack(input int k, input logic [31:0] rdat);
    ev_t e;
    e.kind = EV_ACK; e.g = 2'(k); e.ack = 4'(1 << k); e.adr = '0; e.dat = '0;
    e.sel = '0; e.we = 1'b0; e.rdat = rdat;
    exp_q.push_back(e);
  endtask

  task automatic exp_to(input int k);
    ev_t e;
    e.kind = EV_TO; e.g = 2'(k); e.ack = '0; e.adr = '0; e.dat = '0;
    e.sel = '0; e.we = 1'b0; e.rdat = '0;
    exp_q.push_back(e);
  endtask

  // Advance one cycle; masters in drop_mask release stb after their ack.
  task automatic step();
    @(posedge clk);
    #1;
    s_stb = s_stb & ~(ack_seen & drop_mask);
  endtask

  task automatic do_reset();
    rst = 1'b1; s_stb = '0; slave_en = 1'b1; slave_lat = -1; drop_mask = 4'hF;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) step();
    @(negedge clk);
    check("drain_pending", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_grant"}, 64'(grant), 64'd3);
    check({tag, "_m_stb"}, 64'(m_stb), 64'd0);
    check({tag, "_s_ack"}, 64'(s_ack), 64'd0);
    check({tag, "_timeout"}, 64'(timeout), 64'd0);
  endtask

  task automatic mon_event(input int kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      check("unexpected_event", 64'(kind), 64'd0);
      return;
    end
    e = exp_q.pop_front();
    check("ev_kind", 64'(kind), 64'(e.kind));
    case (kind)
      EV_GRANT: begin
        check("gnt_index", 64'(grant), 64'(e.g));
        check("gnt_adr", 64'(m_adr), 64'(e.adr));
        check("gnt_dat", 64'(m_dat_o), 64'(e.dat));
        check("gnt_sel", 64'(m_sel), 64'(e.sel));
        check("gnt_we", 64'(m_we), 64'(e.we));
      end
      EV_ACK: begin
        check("ack_vec", 64'(s_ack), 64'(e.ack));
        check("ack_rdat", 64'(s_dat_o), 64'(e.rdat));
      end
      default: begin
        check("to_grant", 64'(grant), 64'(e.g));
        check("to_s_ack", 64'(s_ack), 64'd0);
        check("to_m_stb", 64'(m_stb), 64'd0);
      end
    endcase
  endtask

  // Monitor: pops the scoreboard whenever a grant, ack or timeout appears.
  initial begin
    forever begin
      @(negedge clk);
      ack_seen = s_ack;
      if (busy && !busy_prev) mon_event(EV_GRANT);
      if (s_ack != '0) mon_event(EV_ACK);
      if (timeout) mon_event(EV_TO);
      busy_prev = busy;
    end
  end

  // Slave model: acks slave_lat cycles after stb is first seen; <0 never acks.
  initial begin
    m_ack = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (slave_en) begin
        if (m_stb && slave_lat >= 0) begin
          if (slave_cnt == slave_lat) begin
            m_ack = 1'b1; slave_cnt = 0;
          end else begin
            m_ack = 1'b0; slave_cnt++;
          end
        end else begin
          m_ack = 1'b0; slave_cnt = 0;
        end
      end
    end
  end

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Directed stimulus.
  initial begin
    int got;
    int nb;
    rst = 1'b1; s_adr = '0; s_dat_i = '0; s_sel = '0; s_we = '0; s_stb = '0;
    m_dat_i = '0;
    for (int k = 0; k < 4; k++) set_master(k, '0, '0, '0, 1'b0);

    // Reset state and single-master read.
    do_reset();
    @(negedge clk);
    check_reset_vals("reset");
    step();
    set_master(0, 30'h4, 32'h0, 4'hF, 1'b0);
    m_dat_i = 32'h12345678; slave_lat = 3;
    exp_grant(0); exp_ack(0, 32'h12345678);
    s_stb[0] = 1'b1;
    @(negedge clk);
    check("lat_cycle_t", 64'(m_stb), 64'd0);
    step();
    @(negedge clk);
    check("lat_cycle_t1", 64'(m_stb), 64'd1);
    got = 0;
    for (int i = 0; i < 10 && got == 0; i++) begin
      step();
      @(negedge clk);
      if (s_ack != '0) got = 1;
    end
    check("single_ack_wait", 64'(got), 64'd1);
    step();
    @(negedge clk);
    check("single_idle_after_ack", 64'(busy), 64'd0);
    drain();

    // Contention: two writers, grant 0 then 1 with a bubble.
    do_reset();
    set_master(0, 30'h00000001, 32'hAAAAAAAA, 4'h8, 1'b1);
    set_master(1, 30'h11111111, 32'h87654321, 4'h5, 1'b1);
    m_dat_i = 32'hDEAD0001; slave_lat = 1;
    exp_grant(0); exp_ack(0, 32'hDEAD0001);
    exp_grant(1); exp_ack(1, 32'hDEAD0001);
    s_stb = 4'b0011;
    drain();

    // Fairness: all four hold stb, immediate ack -> 0,1,2,3,0,1.
    do_reset();
    for (int k = 0; k < 4; k++)
      set_master(k, 30'(32'h100 + k), 32'hC0DE0000 + 32'(k), 4'(1 << k), k[0]);
    m_dat_i = 32'h0F0F0F0F; slave_lat = 0; drop_mask = 4'h0;
    for (int n = 0; n < 6; n++) begin
      exp_grant(n % 4); exp_ack(n % 4, 32'h0F0F0F0F);
    end
    s_stb = 4'hF;
    repeat (12) step();
    s_stb = 4'h0;
    drain();

    // Abort: master 1 drops stb while master 0 waits.
    do_reset();
    set_master(0, 30'h20, 32'h1, 4'hF, 1'b1);
    set_master(1, 30'h24, 32'h2, 4'h3, 1'b0);
    m_dat_i = 32'h55AA55AA;
    exp_grant(1); exp_grant(0); exp_ack(0, 32'h55AA55AA);
    s_stb[1] = 1'b1;
    step();
    s_stb[0] = 1'b1;
    step();
    step();
    s_stb[1] = 1'b0;
    @(negedge clk);
    check("abort_m_stb", 64'(m_stb), 64'd0);
    step();
    slave_lat = 1;
    @(negedge clk);
    check("abort_idle", 64'(busy), 64'd0);
    step();
    @(negedge clk);
    check("abort_next_busy", 64'(busy), 64'd1);
    check("abort_next_grant", 64'(grant), 64'd0);
    drain();

    // Timeout: slave never acks master 2.
    do_reset();
    set_master(2, 30'h3000, 32'h0, 4'hF, 1'b0);
    exp_grant(2); exp_to(2);
    s_stb[2] = 1'b1;
    got = 0; nb = 0;
    for (int i = 0; i < 20 && got == 0; i++) begin
      step();
      @(negedge clk);
      if (busy) nb++;
      if (timeout) got = 1;
    end
    check("to_seen", 64'(got), 64'd1);
    check("to_busy_cycles", 64'(nb), 64'd8);
    step();
    s_stb = '0;
    @(negedge clk);
    check("to_after_busy", 64'(busy), 64'd0);
    check("to_after_m_stb", 64'(m_stb), 64'd0);
    drain();

    // Reset mid-access with a late ack during reset.
    do_reset();
    set_master(1, 30'h44, 32'h0, 4'hF, 1'b0);
    set_master(0, 30'h40, 32'h0, 4'hF, 1'b0);
    m_dat_i = 32'h99887766;
    exp_grant(1);
    s_stb[1] = 1'b1;
    step();
    step();
    slave_en = 1'b0; m_ack = 1'b0; rst = 1'b1;
    step();
    m_ack = 1'b1;
    @(negedge clk);
    check_reset_vals("midrst");
    step();
    rst = 1'b0; m_ack = 1'b0; slave_en = 1'b1; slave_lat = 0; drop_mask = 4'hF;
    exp_grant(0); exp_ack(0, 32'h99887766);
    exp_grant(1); exp_ack(1, 32'h99887766);
    s_stb = 4'b0011;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
